// File: rtl/c64_bus_ctrl.sv
// C64 memory/bus stage for a 6502 core: 6510 port, banked ROM fetch, wait-stated I/O, internal RAM.
// Optional define CHARROM_EN maps the character ROM into $D000-$DFFF when CHAREN=0 and adds char_sel.
module c64_bus_ctrl #(
    parameter int RAM_AW     = 16,
    parameter int IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ab,
    input  logic [7:0]  cpu_do,
    input  logic        we,
    output logic [7:0]  di,
    output logic        rdy,
    output logic        rom_sel,
    output logic [12:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        io_req,
    output logic        io_we,
    output logic [11:0] io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack,
`ifdef CHARROM_EN
    output logic        char_sel,
`endif
    output logic [7:0]  port_out
);
    localparam int CW = $clog2(IO_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ROM_RD, IO_ACC} state_t;

    state_t        state_q, state_d;
    logic [7:0]    di_q, di_d;
    logic          io_req_q, io_req_d;
    logic          io_we_q, io_we_d;
    logic [11:0]   io_addr_q, io_addr_d;
    logic [7:0]    io_wdata_q, io_wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ddr_q, ddr_d;
    logic [7:0]    pdata_q, pdata_d;
    logic          rom_sel_q, rom_sel_d;
    logic [12:0]   rom_addr_q, rom_addr_d;
    logic          rdy_c, ram_we;

    logic [7:0] mem [2**RAM_AW];

    logic loram, hiram, charen;
    logic is_port, in_d, basic_hit, kern_hit, io_hit, char_hit, rom_hit, timeout;

    assign port_out = (pdata_q & ddr_q) | ~ddr_q;
    assign loram    = port_out[0];
    assign hiram    = port_out[1];
    assign charen   = port_out[2];

    assign is_port   = (ab[15:1] == 15'd0);
    assign in_d      = (ab[15:12] == 4'hD);
    assign basic_hit = !we && (ab[15:13] == 3'b101) && loram && hiram;
    assign kern_hit  = !we && (ab[15:13] == 3'b111) && hiram;
    assign io_hit    = in_d && charen && (loram || hiram);
`ifdef CHARROM_EN
    logic char_q, char_d;
    assign char_hit = !we && in_d && !charen && (loram || hiram);
    assign char_d   = (state_q == IDLE) ? char_hit : char_q;
    assign char_sel = char_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) char_q <= 1'b0;
        else        char_q <= char_d;
    end
`else
    assign char_hit = 1'b0;
`endif
    assign rom_hit = basic_hit || kern_hit || char_hit;
    assign timeout = (cnt_q == CW'(IO_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        di_d       = di_q;
        io_req_d   = io_req_q;
        io_we_d    = io_we_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        cnt_d      = cnt_q;
        ddr_d      = ddr_q;
        pdata_d    = pdata_q;
        rom_sel_d  = rom_sel_q;
        rom_addr_d = rom_addr_q;
        rdy_c      = 1'b1;
        ram_we     = 1'b0;
        case (state_q)
            IDLE: begin
                // ROM address is presented combinationally so data returns in the next cycle
                rom_sel_d  = kern_hit;
                rom_addr_d = char_hit ? {1'b0, ab[11:0]} : ab[12:0];
                if (io_hit) begin
                    rdy_c      = 1'b0;
                    state_d    = IO_ACC;
                    io_req_d   = 1'b1;
                    io_we_d    = we;
                    io_addr_d  = ab[11:0];
                    io_wdata_d = cpu_do;
                    cnt_d      = '0;
                end else if (rom_hit) begin
                    rdy_c   = 1'b0;
                    state_d = ROM_RD;
                end else if (we) begin
                    ram_we = reset;
                    if (is_port && !ab[0]) ddr_d   = cpu_do;
                    if (is_port &&  ab[0]) pdata_d = cpu_do;
                end else if (is_port) begin
                    di_d = ab[0] ? pdata_q : ddr_q;
                end else begin
                    di_d = mem[ab[RAM_AW-1:0]];
                end
            end
            ROM_RD: begin
                di_d    = rom_data;
                state_d = IDLE;
            end
            IO_ACC: begin
                cnt_d = cnt_q + CW'(1);
                rdy_c = io_ack || timeout;
                if (io_ack || timeout) begin
                    if (!io_we_q) di_d = io_ack ? io_rdata : 8'hFF;
                    io_req_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            di_q       <= 8'h00;
            io_req_q   <= 1'b0;
            io_we_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            cnt_q      <= '0;
            ddr_q      <= 8'h00;
            pdata_q    <= 8'h00;
            rom_sel_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            di_q       <= di_d;
            io_req_q   <= io_req_d;
            io_we_q    <= io_we_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            cnt_q      <= cnt_d;
            ddr_q      <= ddr_d;
            pdata_q    <= pdata_d;
            rom_sel_q  <= rom_sel_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // RAM is deliberately not reset; port writes also land here
    always_ff @(posedge clk) begin
        if (ram_we) mem[ab[RAM_AW-1:0]] <= cpu_do;
    end

    assign di       = di_q;
    assign rdy      = !reset || rdy_c;
    assign rom_sel  = rom_sel_d;
    assign rom_addr = rom_addr_d;
    assign io_req   = io_req_q;
    assign io_we    = io_we_q;
    assign io_addr  = io_addr_q;
    assign io_wdata = io_wdata_q;
endmodule

// File: tb/tb_c64_bus_ctrl.sv
// Bench for c64_bus_ctrl: transaction-level memory-map model plus per-cycle compare of bus outputs.
module tb_c64_bus_ctrl;
    localparam int T = 16;
    localparam int K_RAM = 0, K_PORT = 1, K_BASIC = 2, K_KERN = 3, K_IO = 4, K_CHAR = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ab;
    logic [7:0]  cpu_do;
    logic        we;
    logic [7:0]  di;
    logic        rdy;
    logic        rom_sel;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic        io_req, io_we;
    logic [11:0] io_addr;
    logic [7:0]  io_wdata, io_rdata;
    logic        io_ack;
    logic [7:0]  port_out;
    logic        char_sel_w;

    always #5 clk = ~clk;

    c64_bus_ctrl #(.RAM_AW(16), .IO_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di), .rdy(rdy),
        .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
`ifdef CHARROM_EN
        .char_sel(char_sel_w),
`endif
        .port_out(port_out)
    );
`ifndef CHARROM_EN
    assign char_sel_w = 1'b0;
`endif

    // Synchronous ROM device: contents are a simple function of address per ROM
    always @(posedge clk)
        rom_data <= char_sel_w ? (rom_addr[7:0] ^ 8'h3C) :
                    rom_sel    ? (rom_addr[7:0] ^ 8'hC8) : (rom_addr[7:0] ^ 8'h5A);

    int checks = 0, failures = 0;
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // Model state
    logic [7:0] mem_m [0:65535];
    logic [7:0] ddr_m, pdata_m, di_m;

    function automatic logic [7:0] po_m();
        return (pdata_m & ddr_m) | ~ddr_m;
    endfunction

    function automatic int kind_of(input logic [15:0] a, input bit w);
        logic [7:0] po;
        bit lo, hi, ch, in_d;
        po = po_m();
        lo = po[0]; hi = po[1]; ch = po[2];
        in_d = (a >= 16'hD000) && (a <= 16'hDFFF);
        if (a <= 16'h0001) return K_PORT;
        if (in_d && ch && (lo || hi)) return K_IO;
        if (w) return K_RAM;
        if (a >= 16'hA000 && a <= 16'hBFFF && lo && hi) return K_BASIC;
        if (a >= 16'hE000 && hi) return K_KERN;
`ifdef CHARROM_EN
        if (in_d && !ch && (lo || hi)) return K_CHAR;
`endif
        return K_RAM;
    endfunction

    // Expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_rdy, exp_io_req, exp_io_we, exp_rom, exp_rom_sel, exp_char;
    logic [7:0]  exp_di, exp_port_out, exp_io_wdata;
    logic [11:0] exp_io_addr;
    logic [12:0] exp_rom_addr;
    int          stall_cnt, ioreq_cnt;
    logic        cap_rom_sel;
    logic [12:0] cap_rom_addr;

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("rdy", rdy, exp_rdy);
            chk("di", di, exp_di);
            chk("io_req", io_req, exp_io_req);
            chk("port_out", port_out, exp_port_out);
            if (exp_io_req) begin
                chk("io_addr", io_addr, exp_io_addr);
                chk("io_we", io_we, exp_io_we);
                if (exp_io_we) chk("io_wdata", io_wdata, exp_io_wdata);
            end
            if (exp_rom) begin
                chk("rom_addr", rom_addr, exp_rom_addr);
                if (!exp_char) chk("rom_sel", rom_sel, exp_rom_sel);
                chk("char_sel", char_sel_w, exp_char);
                cap_rom_sel  = rom_sel;
                cap_rom_addr = rom_addr;
            end
            if (!rdy) stall_cnt++;
            if (io_req) ioreq_cnt++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the access completes
    task automatic access(input logic [15:0] a, input bit w, input logic [7:0] d,
                          input int ack_at, input logic [7:0] rdata);
        int k, n;
        bit acked;
        logic [7:0] res;
        k = kind_of(a, w);
        acked = (ack_at >= 1) && (ack_at <= T);
        case (k)
            K_BASIC, K_KERN, K_CHAR: n = 2;
            K_IO:    n = 1 + (acked ? ack_at : T);
            default: n = 1;
        endcase
        case (k)
            K_PORT:  res = a[0] ? pdata_m : ddr_m;
            K_BASIC: res = a[7:0] ^ 8'h5A;
            K_KERN:  res = a[7:0] ^ 8'hC8;
            K_CHAR:  res = a[7:0] ^ 8'h3C;
            K_IO:    res = acked ? rdata : 8'hFF;
            default: res = mem_m[a];
        endcase
        stall_cnt = 0; ioreq_cnt = 0;
        ab = a; we = w; cpu_do = d; io_rdata = rdata;
        for (int c = 1; c <= n; c++) begin
            io_ack       = (k == K_IO) && acked && (c - 1 == ack_at);
            exp_rdy      = (c == n);
            exp_di       = di_m;
            exp_port_out = po_m();
            exp_io_req   = (k == K_IO) && (c >= 2);
            exp_io_addr  = a[11:0];
            exp_io_we    = w;
            exp_io_wdata = d;
            exp_rom      = (k == K_BASIC) || (k == K_KERN) || (k == K_CHAR);
            exp_rom_sel  = (k == K_KERN);
            exp_char     = (k == K_CHAR);
            exp_rom_addr = (k == K_CHAR) ? {1'b0, a[11:0]} : a[12:0];
            chk_en = 1'b1;
            @(posedge clk); #1;
        end
        io_ack = 1'b0;
        chk_en = 1'b0;
        if (!w) di_m = res;
        if (w && k != K_IO) begin
            mem_m[a] = d;
            if (a == 16'h0000) ddr_m = d;
            if (a == 16'h0001) pdata_m = d;
        end
    endtask

    initial begin
        reset = 1'b0; ab = 16'h0000; we = 1'b0; cpu_do = 8'h00; io_ack = 1'b0; io_rdata = 8'h00;
        ddr_m = 8'h00; pdata_m = 8'h00; di_m = 8'h00;
        #3;
        chk("rst_di", di, 8'h00);
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_io_req", io_req, 1'b0);
        chk("rst_io_we", io_we, 1'b0);
        chk("rst_port_out", port_out, 8'hFF);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        access(16'hFFFC, 0, 8'h00, 0, 8'h00);
        chk("lit_kernal_di", di, 8'h34);
        chk("lit_kernal_stall", stall_cnt, 1);
        chk("lit_kernal_sel", cap_rom_sel, 1'b1);
        chk("lit_kernal_addr", cap_rom_addr, 13'h1FFC);

        access(16'hA000, 1, 8'h55, 0, 8'h00);
        access(16'hA000, 0, 8'h00, 0, 8'h00);
        chk("lit_basic_di", di, 8'h5A);
        access(16'h0002, 1, 8'h11, 0, 8'h00);
        access(16'h0002, 0, 8'h00, 0, 8'h00);

        access(16'hD020, 0, 8'h00, 3, 8'h0E);
        chk("lit_io_di", di, 8'h0E);
        chk("lit_io_req_cycles", ioreq_cnt, 3);
        chk("lit_io_addr", io_addr, 12'h020);
        access(16'hD020, 1, 8'h01, 0, 8'h00);
        chk("lit_io_timeout_cycles", ioreq_cnt, T);
        access(16'hD021, 1, 8'hA7, 2, 8'h00);
        access(16'hD022, 0, 8'h00, 0, 8'h00);
        chk("lit_io_timeout_ff", di, 8'hFF);
        access(16'hD023, 0, 8'h00, T, 8'h42);
        chk("lit_io_ack_on_timeout", di, 8'h42);
        access(16'hD024, 0, 8'h00, 1, 8'h99);
        access(16'h0000, 0, 8'h00, 0, 8'h00);
        access(16'h0001, 0, 8'h00, 0, 8'h00);

        access(16'h0000, 1, 8'h07, 0, 8'h00);
        access(16'h0001, 1, 8'h00, 0, 8'h00);
        chk("lit_port_out_f8", port_out, 8'hF8);
        access(16'hA000, 0, 8'h00, 0, 8'h00);
        chk("lit_ram_under_basic", di, 8'h55);
        chk("lit_ram_under_basic_stall", stall_cnt, 0);
        access(16'h0000, 0, 8'h00, 0, 8'h00);
        access(16'hD020, 1, 8'h77, 0, 8'h00);
        access(16'hD020, 0, 8'h00, 0, 8'h00);
        access(16'hE000, 1, 8'h99, 0, 8'h00);
        access(16'hE000, 0, 8'h00, 0, 8'h00);

        access(16'h0001, 1, 8'h02, 0, 8'h00);
        access(16'hE000, 0, 8'h00, 0, 8'h00);
        access(16'hA000, 0, 8'h00, 0, 8'h00);
        access(16'hD020, 0, 8'h00, 0, 8'h00);
        access(16'h0001, 1, 8'h05, 0, 8'h00);
        access(16'hD020, 0, 8'h00, 1, 8'h3C);
        access(16'hE000, 0, 8'h00, 0, 8'h00);
        access(16'h0001, 0, 8'h00, 0, 8'h00);

        // Reset asserted during IO_ACC
        ab = 16'hD030; we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_io_req", io_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_io_req", io_req, 1'b0);
        chk("rst_mid_rdy", rdy, 1'b1);
        chk("rst_mid_di", di, 8'h00);
        chk("rst_mid_port_out", port_out, 8'hFF);
        ab = 16'h0000;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        ddr_m = 8'h00; pdata_m = 8'h00; di_m = 8'h00;

        access(16'h0002, 0, 8'h00, 0, 8'h00);
        chk("lit_ram_kept", di, 8'h11);
        access(16'hFFFC, 0, 8'h00, 0, 8'h00);
        access(16'hE000, 1, 8'h12, 0, 8'h00);
        access(16'hE000, 0, 8'h00, 0, 8'h00);
        access(16'hD000, 0, 8'h00, 2, 8'h5B);

`ifdef CHARROM_EN
        access(16'h0000, 1, 8'h07, 0, 8'h00);
        access(16'h0001, 1, 8'h03, 0, 8'h00);
        access(16'hD000, 0, 8'h00, 0, 8'h00);
        chk("lit_char_stall", stall_cnt, 1);
        chk("lit_char_addr", cap_rom_addr, 13'h0000);
        chk("lit_char_di", di, 8'h3C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
